dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the rv32i core: the memory-side end of the load/store request/response interface the core's LSU drives. It accepts one word-aligned read or byte-enabled write per transaction, waits a configurable number of cycles, and returns read data or an error over a valid/ready response channel. Bench and FPGA top instantiate it beside `top` as the data memory model.

## Interface
- `DEPTH_WORDS`, 1024, number of 32-bit words; power of two, ≥ 4.
- `WAIT_CYCLES`, 1, extra cycles between acceptance and response; 0..15.
- `clk`  in  1  clock, rising edge.
- `areset_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  XLEN  byte address.
- `req_wdata`  in  XLEN  write data.
- `req_be`  in  4  byte enables (bit i → bits 8i+7:8i).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  core accepts response.
- `rsp_rdata`  out  XLEN  read data; 0 for writes and errors.
- `rsp_err`  out  1  misaligned or out-of-range access.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, transaction accepted; go to WAIT (counter loaded with WAIT_CYCLES), or straight to RESP if WAIT_CYCLES=0.
- WAIT: `req_ready`=0; counter decrements each cycle; at 1 → RESP.
- RESP: `rsp_valid`=1, outputs held stable until `rsp_ready`; on handshake → IDLE.
- Error when `req_addr[1:0]`≠0 or `req_addr[31:2]` ≥ DEPTH_WORDS: no array access, `rsp_err`=1, `rsp_rdata`=0.
- Write: bytes with `req_be[i]`=1 updated at acceptance edge; others retained. `req_be`=0 write is a legal no-op, `rsp_err`=0.
- Read: full word captured into response register at acceptance edge; `req_be` ignored.
- Request inputs ignored while `req_ready`=0.

## Timing
- Reset (synchronous, `areset_n`=0 at rising edge): state IDLE, `req_ready`=1 after that edge, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter 0. Array contents not cleared.
- Latency: request accepted in cycle c → `rsp_valid` first high in cycle c+1+WAIT_CYCLES.
- Response handshake in cycle d → `rsp_valid`=0 and `req_ready`=1 in cycle d+1; no back-to-back acceptance in the handshake cycle. Throughput: one transaction per 2+WAIT_CYCLES cycles minimum.
- Write accepted in cycle c is visible to any read accepted later.
- `rsp_ready` high before RESP has no effect; backpressure in RESP may last indefinitely.
- Reset asserted mid-WAIT or mid-RESP: transaction dropped, no response; a write already committed at acceptance stays committed.

## Configuration
- `DMEM_STATS_EN` defined: adds outputs `stat_reads`, `stat_writes`, `stat_errs` (each 32-bit, out), incremented on response handshake by transaction type (errors count only in `stat_errs`), saturating at 0xFFFF_FFFF, reset to 0.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Structure
- `rv32i_pkg`: `XLEN`, `dmem_state_t` enum (IDLE/WAIT/RESP), `DMEM_BE_WIDTH`=4.
- Sub-module `dmem_array`: single-port word array with byte-enable write and registered read, `DEPTH_WORDS` parameter. FSM, counter, error check, and stats stay in `dmem_responder`.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10 with be=0xF, read 0x10 → `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, `rsp_valid` at c+1+WAIT_CYCLES.
- Write 0x000000AA to 0x10 with be=0x1 → read returns 0xDEADBEAA; be=0x0 write → unchanged, `rsp_err`=0.
- Read 0x11 and read 4*DEPTH_WORDS → `rsp_err`=1, `rsp_rdata`=0; target word unchanged.
- Hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_rdata` stable, `req_ready`=0; release → `req_ready`=1 next cycle.
- Pulse `areset_n`=0 during WAIT → `rsp_valid` never rises for that transaction, `req_ready`=1 after the reset edge; preceding write still readable.
- With `DMEM_STATS_EN`: 3 reads, 2 writes, 1 misaligned → `stat_reads`=3, `stat_writes`=2, `stat_errs`=1; WAIT_CYCLES=0 rerun gives latency 1.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared rv32i types and widths used by the core-side memory models.
package rv32i_pkg;

  localparam int XLEN          = 32;
  localparam int DMEM_BE_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with byte-enable write and registered read.
import rv32i_pkg::*;

module dmem_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic                         we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [XLEN-1:0]              wdata,
  input  logic [DMEM_BE_WIDTH-1:0]     be,
  output logic [XLEN-1:0]              rdata
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // Contents are deliberately not reset; rdata only changes on an enabled read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DMEM_BE_WIDTH; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed wait, valid/ready response.
// Optional DMEM_STATS_EN adds saturating read/write/error counters.
import rv32i_pkg::*;

module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     areset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [XLEN-1:0]          req_addr,
  input  logic [XLEN-1:0]          req_wdata,
  input  logic [DMEM_BE_WIDTH-1:0] req_be,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_rdata,
  output logic                     rsp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]              stat_reads,
  output logic [31:0]              stat_writes,
  output logic [31:0]              stat_errs
`endif
);

  localparam int              AW          = $clog2(DEPTH_WORDS);
  localparam logic [3:0]      WAIT_LOAD   = 4'(WAIT_CYCLES);
  localparam logic [XLEN-3:0] DEPTH_LIMIT = (XLEN-2)'(DEPTH_WORDS);

  dmem_state_t     state, state_next;
  logic [3:0]      cnt, cnt_next;
  logic            err_q, err_next;
  logic            is_read_q, is_read_next;
  logic            is_write_q, is_write_next;
  logic            accept;
  logic            addr_err;
  logic [XLEN-1:0] arr_rdata;

  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[XLEN-1:2] >= DEPTH_LIMIT);
  assign accept   = (state == IDLE) && req_valid && areset_n;

  // Writes commit and reads capture on the acceptance edge itself.
  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .en    (accept && !addr_err),
    .we    (req_we),
    .addr  (req_addr[AW+1:2]),
    .wdata (req_wdata),
    .be    (req_be),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      err_q      <= 1'b0;
      is_read_q  <= 1'b0;
      is_write_q <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      err_q      <= err_next;
      is_read_q  <= is_read_next;
      is_write_q <= is_write_next;
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    err_next      = err_q;
    is_read_next  = is_read_q;
    is_write_next = is_write_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          err_next      = addr_err;
          is_read_next  = !req_we && !addr_err;
          is_write_next = req_we && !addr_err;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_next = RESP;
          cnt_next   = 4'd0;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next    = IDLE;
          err_next      = 1'b0;
          is_read_next  = 1'b0;
          is_write_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The array's read register is not reset, so gate it to zero unless a read is being answered.
  assign rsp_rdata = (rsp_valid && is_read_q) ? arr_rdata : '0;
  assign rsp_err   = err_q;

`ifdef DMEM_STATS_EN
  logic rsp_fire;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      stat_reads  <= 32'd0;
      stat_writes <= 32'd0;
      stat_errs   <= 32'd0;
    end else if (rsp_fire) begin
      if (err_q) begin
        if (stat_errs != 32'hFFFF_FFFF) stat_errs <= stat_errs + 32'd1;
      end else if (is_read_q) begin
        if (stat_reads != 32'hFFFF_FFFF) stat_reads <= stat_reads + 32'd1;
      end else if (is_write_q) begin
        if (stat_writes != 32'hFFFF_FFFF) stat_writes <= stat_writes + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder plus backpressure and mid-wait reset sequences.
module tb_dmem_responder;
  import rv32i_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int WAITC   = 1;
  localparam int TIMEOUT = 40;
  localparam int NVEC    = 13;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  logic        clk       = 1'b0;
  logic        areset_n  = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [31:0] req_addr  = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be    = 4'd0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

`ifdef DMEM_STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_errs;
  int exp_reads  = 0;
  int exp_writes = 0;
  int exp_errs   = 0;
`endif

  vec_t vecs [NVEC];

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
`ifdef DMEM_STATS_EN
    ,
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
    .stat_errs   (stat_errs)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Runs one full transaction and checks latency and post-handshake state along the way.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input string name,
                               output logic [31:0] rdata, output logic err);
    int lat;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    lat = 0;
    while (!req_ready && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({name, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({name, " latency"}, 32'(lat), 32'(1 + WAITC));
    rdata = rsp_rdata;
    err   = rsp_err;
`ifdef DMEM_STATS_EN
    if (addr[1:0] != 2'b00 || addr >= 32'(4 * DEPTH)) exp_errs++;
    else if (we) exp_writes++;
    else exp_reads++;
`endif
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput({name, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
    checkOutput({name, " req_ready back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        seen;
    int          lat;

    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0, "wr full"};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0, "rd full"};
    vecs[2]  = '{1'b1, 32'h10,   32'h000000AA, 4'h1, 32'h0,        1'b0, "wr byte0"};
    vecs[3]  = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEAA, 1'b0, "rd byte0"};
    vecs[4]  = '{1'b1, 32'h10,   32'h12345678, 4'h0, 32'h0,        1'b0, "wr be0"};
    vecs[5]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0, "rd after be0"};
    vecs[6]  = '{1'b0, 32'h11,   32'h0,        4'h0, 32'h0,        1'b1, "rd misaligned"};
    vecs[7]  = '{1'b0, 32'h1000, 32'h0,        4'h0, 32'h0,        1'b1, "rd out of range"};
    vecs[8]  = '{1'b1, 32'h12,   32'h11111111, 4'hF, 32'h0,        1'b1, "wr misaligned"};
    vecs[9]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0, "rd after err wr"};
    vecs[10] = '{1'b1, 32'hFFC,  32'hA5A5A5A5, 4'hF, 32'h0,        1'b0, "wr last word"};
    vecs[11] = '{1'b1, 32'hFFC,  32'hCAFEF00D, 4'hA, 32'h0,        1'b0, "wr bytes 1,3"};
    vecs[12] = '{1'b0, 32'hFFC,  32'h0,        4'h0, 32'hCAA5F0A5, 1'b0, "rd last word"};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
    areset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].name, rd, er);
      checkOutput({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, " err"}, 32'(er), 32'(vecs[i].exp_err));
    end

    // Backpressure: response held for five cycles while a stray write is presented and ignored.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_be    = 4'h0;
    @(posedge clk); #1;
    req_we    = 1'b1;
    req_wdata = 32'h0;
    req_be    = 4'hF;
    lat = 1;
    while (!rsp_valid && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("bp latency", 32'(lat), 32'(1 + WAITC));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput("bp rsp_valid held", 32'(rsp_valid), 32'd1);
      checkOutput("bp rsp_rdata held", rsp_rdata, 32'hDEADBEAA);
      checkOutput("bp req_ready low", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("bp release req_ready", 32'(req_ready), 32'd1);
    checkOutput("bp release rsp_valid", 32'(rsp_valid), 32'd0);
`ifdef DMEM_STATS_EN
    exp_reads++;
`endif
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, "rd after stray wr", rd, er);
    checkOutput("rd after stray wr rdata", rd, 32'hDEADBEAA);

    // Reset during WAIT: the pending read vanishes, the earlier write survives.
    applyStimulus(1'b1, 32'h20, 32'h5555AAAA, 4'hF, "wr before reset", rd, er);
    checkOutput("wr before reset err", 32'(er), 32'd0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("mid-wait rsp_valid", 32'(rsp_valid), 32'd0);
    areset_n = 1'b0;
    @(posedge clk); #1;
    areset_n = 1'b1;
    checkOutput("post-reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("post-reset rsp_valid", 32'(rsp_valid), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    checkOutput("dropped txn no rsp", 32'(seen), 32'd0);
`ifdef DMEM_STATS_EN
    exp_reads  = 0;
    exp_writes = 0;
    exp_errs   = 0;
`endif
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, "rd after reset", rd, er);
    checkOutput("rd after reset rdata", rd, 32'h5555AAAA);
    checkOutput("rd after reset err", 32'(er), 32'd0);

`ifdef DMEM_STATS_EN
    applyStimulus(1'b0, 32'h13, 32'h0, 4'h0, "stats misaligned", rd, er);
    applyStimulus(1'b1, 32'h24, 32'h1, 4'h3, "stats wr", rd, er);
    checkOutput("stat_reads", stat_reads, 32'(exp_reads));
    checkOutput("stat_writes", stat_writes, 32'(exp_writes));
    checkOutput("stat_errs", stat_errs, 32'(exp_errs));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
